// File: rtl/fib_demux_bank_pkg.sv
// Shared definitions for the Fibonacci demux bank and the 4-to-1 selector that reads it back.
package fib_demux_bank_pkg;

  localparam int FIB_SIZE = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PARTIAL = 2'b01,
    FULL    = 2'b10
  } bank_state_e;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  function automatic logic [3:0] slot_onehot(input logic [1:0] idx);
    logic [3:0] mask;
    mask = 4'b0000;
    case (idx)
      SLOT0:   mask = 4'b0001;
      SLOT1:   mask = 4'b0010;
      SLOT2:   mask = 4'b0100;
      SLOT3:   mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic bank_state_e state_of(input logic [3:0] valid);
    bank_state_e st;
    if (valid == 4'b0000)      st = EMPTY;
    else if (valid == 4'b1111) st = FULL;
    else                       st = PARTIAL;
    return st;
  endfunction

endpackage

// File: rtl/fib_rr_ptr.sv
// 2-bit wrap-around write pointer; a clear and an increment in the same cycle yield 1.
module fib_rr_ptr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [1:0] ptr
);

  logic [1:0] ptr_reg;
  logic [1:0] ptr_next;

  always_comb begin
    ptr_next = clr ? 2'd0 : ptr_reg;
    if (inc) ptr_next = ptr_next + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= 2'd0;
    else        ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fib_demux_bank.sv
// 1-to-4 registered demux bank with validity tracking and auto-mode back-pressure.
// Optional sticky overflow flag `ovf` when FIB_DEMUX_OVF_EN is defined.
module fib_demux_bank
  import fib_demux_bank_pkg::*;
#(
  parameter int SIZE = FIB_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] D,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      S,
  input  logic            auto_mode,
  input  logic            out_ack,
  output logic [SIZE-1:0] Q0,
  output logic [SIZE-1:0] Q1,
  output logic [SIZE-1:0] Q2,
  output logic [SIZE-1:0] Q3,
  output logic [3:0]      slot_valid,
  output logic [1:0]      ptr,
`ifdef FIB_DEMUX_OVF_EN
  output logic            ovf,
`endif
  output logic            all_full
);

  bank_state_e     state_reg;
  bank_state_e     state_next;
  logic [3:0]      valid_reg;
  logic [3:0]      valid_next;
  logic            all_full_reg;
  logic [1:0]      ptr_q;
  logic            xfer;
  logic [1:0]      dest;
  logic [3:0]      wr_mask;
  logic [SIZE-1:0] slot_q [4];

  assign in_ready = !(auto_mode && (state_reg == FULL) && !out_ack);
  assign xfer     = in_valid & in_ready;

  // An ack at the same edge rewinds the pointer first, so an auto write lands in slot 0.
  assign dest    = auto_mode ? (out_ack ? SLOT0 : ptr_q) : S;
  assign wr_mask = xfer ? slot_onehot(dest) : 4'b0000;

  always_comb begin
    valid_next = (out_ack ? 4'b0000 : valid_reg) | wr_mask;
    state_next = state_of(valid_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      valid_reg    <= 4'b0000;
      all_full_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      valid_reg    <= valid_next;
      all_full_reg <= (state_next == FULL);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_slot
      logic [SIZE-1:0] slot_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           slot_reg <= '0;
        else if (wr_mask[gi]) slot_reg <= D;
      end
      assign slot_q[gi] = slot_reg;
    end
  endgenerate

  fib_rr_ptr u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer & auto_mode),
    .clr   (out_ack),
    .ptr   (ptr_q)
  );

`ifdef FIB_DEMUX_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf_reg <= 1'b0;
    else if (out_ack)               ovf_reg <= 1'b0;
    else if (in_valid && !in_ready) ovf_reg <= 1'b1;
  end

  assign ovf = ovf_reg;
`endif

  assign Q0         = slot_q[0];
  assign Q1         = slot_q[1];
  assign Q2         = slot_q[2];
  assign Q3         = slot_q[3];
  assign slot_valid = valid_reg;
  assign ptr        = ptr_q;
  assign all_full   = all_full_reg;

endmodule

// File: tb/tb_fib_demux_bank.sv
// Directed bench for fib_demux_bank; exercises ovf too when FIB_DEMUX_OVF_EN is defined.
module tb_fib_demux_bank;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] S;
  logic       auto_mode;
  logic       out_ack;
  logic [3:0] Q0, Q1, Q2, Q3;
  logic [3:0] slot_valid;
  logic [1:0] ptr;
  logic       all_full;
`ifdef FIB_DEMUX_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  fib_demux_bank #(.SIZE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D          (D),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .S          (S),
    .auto_mode  (auto_mode),
    .out_ack    (out_ack),
    .Q0         (Q0),
    .Q1         (Q1),
    .Q2         (Q2),
    .Q3         (Q3),
    .slot_valid (slot_valid),
    .ptr        (ptr),
`ifdef FIB_DEMUX_OVF_EN
    .ovf        (ovf),
`endif
    .all_full   (all_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; D = 4'd0; in_valid = 1'b0; S = 2'd0; auto_mode = 1'b0; out_ack = 1'b0;
    #3;
    chk("rst_q0", Q0, 0);
    chk("rst_valid", slot_valid, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_full", all_full, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", in_ready, 1);

    // reset mid-operation
    in_valid = 1'b1; S = 2'd0; D = 4'd3;
    tick();
    S = 2'd1; D = 4'd5;
    tick();
    in_valid = 1'b0;
    chk("mid_q0", Q0, 3);
    chk("mid_q1", Q1, 5);
    chk("mid_valid", slot_valid, 4'b0011);
    chk("mid_ptr_manual", ptr, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q0", Q0, 0);
    chk("async_q1", Q1, 0);
    chk("async_valid", slot_valid, 0);
    #2 rst_n = 1'b1;
    tick();

    // auto fill
    auto_mode = 1'b1; in_valid = 1'b1;
    D = 4'd1; tick();
    chk("fill1_ptr", ptr, 1);
    chk("fill1_full", all_full, 0);
    D = 4'd2; tick();
    D = 4'd3; tick();
    D = 4'd5; tick();
    chk("fill_q0", Q0, 1);
    chk("fill_q1", Q1, 2);
    chk("fill_q2", Q2, 3);
    chk("fill_q3", Q3, 5);
    chk("fill_full", all_full, 1);
    chk("fill_valid", slot_valid, 4'hf);
    chk("fill_ptr_wrap", ptr, 0);
    chk("fill_ready", in_ready, 0);
    D = 4'd8; tick();
    chk("drop_q0", Q0, 1);
    chk("drop_valid", slot_valid, 4'hf);
    chk("drop_ptr", ptr, 0);
    auto_mode = 1'b0; #1;
    chk("manual_ready_full", in_ready, 1);
    auto_mode = 1'b1; #1;

    // drain plus write together
    out_ack = 1'b1; D = 4'd13; #1;
    chk("ack_ready", in_ready, 1);
    tick();
    out_ack = 1'b0; in_valid = 1'b0;
    chk("ackwr_valid", slot_valid, 4'b0001);
    chk("ackwr_q0", Q0, 13);
    chk("ackwr_q1_kept", Q1, 2);
    chk("ackwr_ptr", ptr, 1);
    chk("ackwr_full", all_full, 0);

    // manual overwrite
    auto_mode = 1'b0; S = 2'd2; in_valid = 1'b1; D = 4'd8; #1;
    chk("man_ready", in_ready, 1);
    tick();
    chk("man_q2_first", Q2, 8);
    D = 4'd13; tick();
    in_valid = 1'b0;
    chk("man_q2", Q2, 13);
    chk("man_valid", slot_valid, 4'b0101);
    chk("man_ptr", ptr, 1);

    // idle cycle holds state
    D = 4'd9; tick();
    chk("idle_q2", Q2, 13);
    chk("idle_ptr", ptr, 1);

    // ack alone
    out_ack = 1'b1; tick();
    out_ack = 1'b0;
    chk("ack_valid", slot_valid, 0);
    chk("ack_ptr", ptr, 0);
    chk("ack_q2_kept", Q2, 13);

    // mode switch
    auto_mode = 1'b1; in_valid = 1'b1; D = 4'd1;
    tick(); tick();
    chk("ms_ptr2", ptr, 2);
    auto_mode = 1'b0; S = 2'd0; D = 4'd7; tick();
    chk("ms_ptr_hold", ptr, 2);
    auto_mode = 1'b1; D = 4'd2; tick();
    in_valid = 1'b0;
    chk("ms_q0", Q0, 7);
    chk("ms_q1", Q1, 1);
    chk("ms_q2", Q2, 2);
    chk("ms_ptr3", ptr, 3);
    chk("ms_valid", slot_valid, 4'b0111);

    // fill last slot, then overflow attempt
    in_valid = 1'b1; D = 4'd3; tick();
    chk("ov_full", all_full, 1);
    D = 4'd9; tick();
    in_valid = 1'b0;
    chk("ov_q3", Q3, 3);
    chk("ov_q0", Q0, 7);
`ifdef FIB_DEMUX_OVF_EN
    chk("ovf_set", ovf, 1);
    tick();
    chk("ovf_sticky", ovf, 1);
`endif
    out_ack = 1'b1; tick();
    out_ack = 1'b0;
    chk("ov_ack_valid", slot_valid, 0);
`ifdef FIB_DEMUX_OVF_EN
    chk("ovf_clr", ovf, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
